// File: rtl/mem_responder.sv
// mem_responder: word-organised memory target with a req/ready handshake
// and a programmable number of wait states between acceptance and response.
module mem_responder #(
    parameter int AW   = 6,
    parameter int WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemErr
);
    typedef enum logic [1:0] {IDLE, WAITST, DONE} state_t;
    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] adr_q, wd_q;
    logic        we_q;
    logic [31:0] mem [2**AW];
    logic        accept, go_done, c_we, c_err;
    logic [31:0] c_adr, c_wd;
    logic [AW-1:0] idx;
    // With WAIT=0 the access completes on the accepting edge, so it must use the live inputs.
    assign accept  = (state != WAITST) && MemReq;
    assign go_done = accept ? (WAIT == 0) : (state == WAITST && cnt == 4'd1);
    assign c_adr   = accept ? Adr : adr_q;
    assign c_wd    = accept ? WriteData : wd_q;
    assign c_we    = accept ? MemWrite : we_q;
    assign c_err   = (c_adr >> (AW + 2)) != 32'd0;
    assign idx     = c_adr[AW+1:2];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            adr_q    <= 32'd0;
            wd_q     <= 32'd0;
            we_q     <= 1'b0;
            MemReady <= 1'b0;
            MemErr   <= 1'b0;
            ReadData <= 32'd0;
        end else begin
            MemReady <= go_done;
            MemErr   <= go_done && c_err;
            if (go_done && !c_we) ReadData <= c_err ? 32'd0 : mem[idx];
            if (accept) begin
                adr_q <= Adr;
                wd_q  <= WriteData;
                we_q  <= MemWrite;
                cnt   <= 4'(WAIT);
                state <= (WAIT == 0) ? DONE : WAITST;
            end else if (state == WAITST) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) state <= DONE;
            end else begin
                state <= IDLE;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset && go_done && c_we && !c_err) mem[idx] <= c_wd;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-organised memory target serving the multicycle core's memory port (Adr, WriteData, MemWrite in; ReadData out).
- Accepts one request at a time on a req/ready handshake.
- Inserts a programmable number of wait states, so core-side stall logic can be exercised against realistic memory latency.
- Sits between the core's address/write-data outputs and its instruction and data registers.

Parameters:
- AW, 6, log2 of memory depth in 32-bit words (depth = 2**AW).
- WAIT, 2, wait states between request acceptance and response (0..15).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- MemReq  input  1  request strobe; sampled only when the block can accept
- MemWrite  input  1  1 = write, 0 = read; qualified by MemReq
- Adr  input  32  byte address; word index = Adr[AW+1:2]
- WriteData  input  32  store data; qualified by MemReq and MemWrite
- ReadData  output  32  read result; held stable until the next accepted read completes
- MemReady  output  1  one-cycle pulse: request completed
- MemErr  output  1  one-cycle pulse alongside MemReady: address error on that request

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, MemReady=0, MemErr=0, ReadData=0, wait counter=0.
  - Latched request and any pending write are discarded.
  - Memory array contents are not reset.
- States:
  - IDLE: MemReady=0. If MemReq=1, latch Adr, WriteData and MemWrite, and load counter=WAIT. Next state is WAITST if WAIT>0, else DONE.
  - WAITST: decrement the counter each cycle. When the counter equals 1, go to DONE at the next edge. MemReq is ignored.
  - DONE: MemReady=1 for exactly this cycle. If MemReq=1, accept a new request exactly as IDLE does (back-to-back). Otherwise go to IDLE.
- Latency:
  - A request accepted at edge E0 gives MemReady high during the cycle following edge E0+WAIT.
  - WAIT=0 gives MemReady in the cycle right after acceptance.
  - Throughput is one access per WAIT+1 cycles with back-to-back requests.
- Read access:
  - ReadData is loaded from mem[index] at the edge entering DONE.
  - It holds that value through DONE and all later cycles until the next read's DONE-entry edge.
  - A write does not change ReadData.
- Write access:
  - mem[index] <= WriteData (latched copy) at the edge entering DONE.
  - A read of the same word accepted in that DONE cycle returns the new data.
- Address checks:
  - Adr[1:0] is ignored; all accesses are full-word.
  - Any set bit in Adr[31:AW+2] is an out-of-range error: MemErr=1 with MemReady.
    - An error write is dropped and memory is unchanged.
    - An error read loads ReadData=0.
- Input changes on Adr, WriteData or MemWrite after acceptance do not affect the request in flight.
- MemReady and MemErr are never high outside DONE. MemErr implies MemReady.
- If reset asserts during WAITST or DONE, the block returns to IDLE immediately, the write does not occur, and no MemReady is issued.
- The counter is 4 bits wide. Configuring WAIT>15 is illegal.

Test Plan:
- WAIT=2, write Adr=0x00000010, WriteData=0xDEADBEEF, MemReq pulsed 1 cycle, then read 0x10. Required: each MemReady arrives 3 cycles after acceptance, and the read returns 0xDEADBEEF.
- WAIT=0, back-to-back: hold MemReq=1 for write 0x04 = 0x12345678 then read 0x04. Required: MemReady high on consecutive access slots and ReadData=0x12345678 on the second.
- Read 0x13 after writing 0x10 with 0xCAFEF00D. Required: ReadData=0xCAFEF00D, since byte offset is ignored.
- AW=6, write Adr=0x00000100 with 0x11111111, then read 0x100. Required: MemErr=1 with MemReady on both, ReadData=0, and word 0 unchanged.
- WAIT=3, accept write 0x08 = 0xAAAAAAAA, assert reset low in the 2nd wait cycle. Required: immediate IDLE, MemReady=0, ReadData=0; a later read of 0x08 returns its pre-test value.
- WAIT=2, change Adr and WriteData every cycle during WAITST. Required: the original latched request completes, and MemReq pulses during WAITST are not accepted.
